// File: rtl/pipeline_absorb_fifo.sv
// First-word-fall-through FIFO that absorbs words still in flight
// from an upstream delay pipeline after its throttle is dropped.
module pipeline_absorb_fifo #(
    parameter int DATA_WIDTH   = 16,
    parameter int DEPTH        = 16,
    parameter int PIPE_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     i_input_data,
    input  logic                      i_input_data_valid,
    output logic                      o_input_ready,
    output logic [DATA_WIDTH-1:0]     o_output_data,
    output logic                      o_output_data_valid,
    input  logic                      i_output_ready,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic                      o_empty,
    output logic                      o_full,
    output logic                      o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  push;
    logic                  pop;
    logic                  accept;
    logic [CW-1:0]         slack;

    assign push   = i_input_data_valid;
    assign pop    = (count != '0) && i_output_ready;
    assign accept = push && ((count != CW'(DEPTH)) || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (accept && !pop)
                count <= count + 1'b1;
            else if (!accept && pop)
                count <= count - 1'b1;
            if (push && !accept)
                o_overflow <= 1'b1;
        end
    end

    // Storage is left unreset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (accept && !reset)
            mem[wr_ptr] <= i_input_data;
    end

    assign slack = CW'(DEPTH) - count;

    assign o_count             = count;
    assign o_empty             = (count == '0);
    assign o_full              = (count == CW'(DEPTH));
    assign o_output_data_valid = (count != '0);
    assign o_output_data       = o_output_data_valid ? mem[rd_ptr] : '0;
    assign o_input_ready       = (slack > CW'(PIPE_LATENCY));

endmodule

// File: doc/pipeline_absorb_fifo.md
PIPELINE_ABSORB_FIFO -- requirements
Module: pipeline_absorb_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of data words.
REQ-002 SHALL have parameter DEPTH, default 16, storage entries; power of two, >= 4.
REQ-003 SHALL have parameter PIPE_LATENCY, default 1, upstream cycles in flight after a stall request; 0 <= PIPE_LATENCY < DEPTH.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous reset, active-high.
REQ-006 SHALL have port i_input_data  input  DATA_WIDTH  write data from upstream delay pipeline.
REQ-007 SHALL have port i_input_data_valid  input  1  write strobe; upstream cannot be back-pressured within a cycle.
REQ-008 SHALL have port o_input_ready  output  1  throttle hint to upstream issue point.
REQ-009 SHALL have port o_output_data  output  DATA_WIDTH  head-of-queue data.
REQ-010 SHALL have port o_output_data_valid  output  1  head data valid.
REQ-011 SHALL have port i_output_ready  input  1  downstream accept.
REQ-012 SHALL have port o_count  output  $clog2(DEPTH)+1  entries held, including head.
REQ-013 SHALL have port o_empty  output  1  o_count == 0.
REQ-014 SHALL have port o_full  output  1  o_count == DEPTH.
REQ-015 SHALL have port o_overflow  output  1  sticky; a write was dropped.

Function
REQ-016 SHALL implement a first-word-fall-through circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-017 SHALL define push = i_input_data_valid, pop = o_output_data_valid && i_output_ready.
REQ-018 SHALL accept a push when o_count < DEPTH, or when o_count == DEPTH and pop is asserted in the same cycle.
REQ-019 SHALL, on a push when full without pop, drop the word, leave pointers/count unchanged, and set o_overflow on the next edge.
REQ-020 SHALL update o_count by +1 (push only), -1 (pop only), 0 (both or neither) each cycle.
REQ-021 SHALL present a word pushed into an empty FIFO on o_output_data with o_output_data_valid high exactly 1 cycle after the push edge.
REQ-022 SHALL hold o_output_data and o_output_data_valid stable while o_output_data_valid && !i_output_ready.
REQ-023 SHALL drive o_output_data_valid = (o_count != 0).
REQ-024 SHALL preserve strict FIFO order; no word duplicated or reordered across pointer wrap.
REQ-025 SHALL drive o_input_ready = ((DEPTH - o_count) > PIPE_LATENCY), derived from registered o_count only, so that PIPE_LATENCY in-flight words after deassertion never overflow.
REQ-026 SHALL keep o_overflow high until reset regardless of later pops.
REQ-027 SHALL produce no combinational path from i_input_data_valid or i_input_data to any output.
REQ-028 SHALL ignore i_output_ready while o_output_data_valid is low.

Reset
REQ-029 SHALL, while reset is high at a clock edge, clear pointers, o_count, o_overflow; ignore push and pop that cycle.
REQ-030 SHALL reset outputs to: o_output_data_valid 0, o_output_data 0, o_count 0, o_empty 1, o_full 0, o_overflow 0, o_input_ready 1.
REQ-031 SHALL, on reset asserted mid-operation with data stored, discard all contents; first push after reset release appears 1 cycle later.
REQ-032 SHALL not require reset of storage RAM contents.

Verification
REQ-033 SHALL verify single word: DEPTH=16, push 0x00A5 into empty, i_output_ready=0 -> next cycle o_output_data=0x00A5, valid=1, o_count=1; held stable 5 cycles.
REQ-034 SHALL verify fill/wrap: push 0..15 back-to-back, drain with i_output_ready=1, push 16..40 while draining -> output sequence 0..40 in order, o_full asserted exactly when o_count=16.
REQ-035 SHALL verify throttle: PIPE_LATENCY=3, i_output_ready=0, push continuously -> o_input_ready falls when o_count=13; 3 further pushes land, o_count=16, o_overflow=0.
REQ-036 SHALL verify overflow: full, i_output_ready=0, push 0xBEEF -> o_count stays 16, o_overflow=1 next cycle and stays 1 after full drain; 0xBEEF never output.
REQ-037 SHALL verify simultaneous push+pop when full: o_count=16, push 0x1234 with i_output_ready=1 -> o_count stays 16, o_overflow=0, 0x1234 emerges 16th after.
REQ-038 SHALL verify mid-operation reset: o_count=7, assert reset 1 cycle -> o_count=0, valid=0, o_overflow=0; next push 0x0042 output 1 cycle later.
